// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared types and constants for the common-data-bus arbiter.
//                cdb_t is the broadcast word placed on each CDB write port.
//  Contents    : PREG_W, DATA_W, NUM_CDB_PORTS, cdb_t
//  Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  localparam int PREG_W        = 6;
  localparam int DATA_W        = 32;
  localparam int NUM_CDB_PORTS = 2;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Requester/CDB bundle between the functional units and the
//                CDB arbiter.
//  Signals     : req_valid [NUM_REQ]          requester has a result
//                req_preg  [NUM_REQ][PREG_W]  destination physical register
//                req_data  [NUM_REQ][DATA_W]  result value
//                req_ready [NUM_REQ]          result accepted this cycle
//                cdb       [NUM_PORTS]        registered broadcast words
//  Modports    : master - functional-unit side, slave - arbiter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = NUM_CDB_PORTS
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][PREG_W-1:0] req_preg;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  cdb_t [NUM_PORTS-1:0]           cdb;

  modport master (
    output req_valid, req_preg, req_data,
    input  req_ready, cdb
  );

  modport slave (
    input  req_valid, req_preg, req_data,
    output req_ready, cdb
  );

endinterface
`default_nettype wire

// File: rtl/cdb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_rr_picker
//  Description : Combinational round-robin multi-winner picker. Finds up to
//                NUM_PORTS set bits of i_req scanning upward from i_rr_ptr
//                (wrapping), assigning the k-th found bit to port k.
//  Ports       : i_req      [NUM_REQ]             eligible requesters
//                i_rr_ptr   [PTR_W]               scan start index
//                o_grant    [NUM_PORTS][NUM_REQ]  one-hot grant per port
//                o_gvalid   [NUM_PORTS]           port carries a grant
//                o_last_idx [PTR_W]               index of last winner
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = NUM_CDB_PORTS,
  parameter int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]                i_req,
  input  logic [PTR_W-1:0]                  i_rr_ptr,
  output logic [NUM_PORTS-1:0][NUM_REQ-1:0] o_grant,
  output logic [NUM_PORTS-1:0]              o_gvalid,
  output logic [PTR_W-1:0]                  o_last_idx
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [2*NUM_REQ-1:0] w_req_shr;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotate so that bit 0 of w_rot is requester i_rr_ptr; the doubled vector
  // turns the wrap-around into a plain shift.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_shr = w_req_dbl >> i_rr_ptr;
  assign w_rot     = w_req_shr[NUM_REQ-1:0];

  always_comb begin
    logic [NUM_REQ-1:0]   w_remain;
    logic [NUM_REQ-1:0]   w_pick;
    logic [2*NUM_REQ-1:0] w_unrot;
    int                   w_last_rot;
    int                   w_sum;

    o_grant    = '0;
    o_gvalid   = '0;
    w_remain   = w_rot;
    w_pick     = '0;
    w_unrot    = '0;
    w_last_rot = 0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      // Isolate the lowest remaining set bit, then strip it for the next port.
      w_pick      = w_remain & (-w_remain);
      o_gvalid[p] = |w_remain;
      // Rotate the one-hot back into requester index space.
      w_unrot     = {w_pick, w_pick} << i_rr_ptr;
      o_grant[p]  = w_unrot[2*NUM_REQ-1:NUM_REQ];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_pick[j]) begin
          w_last_rot = j;
        end
      end
      w_remain = w_remain & ~w_pick;
    end

    w_sum = w_last_rot + int'(i_rr_ptr);
    if (w_sum >= NUM_REQ) begin
      w_sum = w_sum - NUM_REQ;
    end
    o_last_idx = PTR_W'(w_sum);
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Shares NUM_PORTS common-data-bus write ports among NUM_REQ
//                result requesters. Round-robin multi-grant arbitration with
//                a valid/ready handshake; winners are registered onto cdb[]
//                one cycle after acceptance. Results targeting p0 are
//                accepted immediately and never broadcast.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                flush - synchronous pipeline flush, blocks all acceptance
//                bus   - cdb_arbiter_if.slave (req_valid/preg/data in,
//                        req_ready/cdb out)
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = NUM_CDB_PORTS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                  r_rr_ptr;
  cdb_t [NUM_PORTS-1:0]              r_cdb;

  logic [NUM_REQ-1:0]                w_is_p0;
  logic [NUM_REQ-1:0]                w_nz_req;
  logic [NUM_REQ-1:0]                w_granted;
  logic [NUM_PORTS-1:0][NUM_REQ-1:0] w_grant;
  logic [NUM_PORTS-1:0]              w_gvalid;
  logic [PTR_W-1:0]                  w_last_idx;
  logic [PTR_W-1:0]                  w_ptr_nxt;
  logic                              w_any_grant;
  cdb_t [NUM_PORTS-1:0]              w_cdb_nxt;

  // p0 is the hard-wired zero register: its writes need no port.
  always_comb begin
    w_is_p0  = '0;
    w_nz_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_is_p0[i]  = bus.req_valid[i] && (bus.req_preg[i] == '0);
      w_nz_req[i] = bus.req_valid[i] && (bus.req_preg[i] != '0);
    end
  end

  cdb_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .i_req      (w_nz_req),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_gvalid   (w_gvalid),
    .o_last_idx (w_last_idx)
  );

  always_comb begin
    w_granted = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_granted = w_granted | w_grant[p];
    end
  end

  assign bus.req_ready = (rst_n && !flush) ? (w_is_p0 | w_granted) : '0;

  // Ports fill in order, so port 0 being used means at least one grant.
  assign w_any_grant = w_gvalid[0] && !flush;
  assign w_ptr_nxt   = (w_last_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                          : w_last_idx + PTR_W'(1);

  // AND-OR payload mux driven by the one-hot grants; idle ports stay all-zero.
  always_comb begin
    w_cdb_nxt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_gvalid[p] && !flush) begin
        w_cdb_nxt[p].valid = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (w_grant[p][i]) begin
            w_cdb_nxt[p].preg = w_cdb_nxt[p].preg | bus.req_preg[i];
            w_cdb_nxt[p].data = w_cdb_nxt[p].data | bus.req_data[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_cdb <= w_cdb_nxt;
      if (w_any_grant) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.cdb = r_cdb;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter: directed scenarios
//                followed by randomized traffic compared against a
//                scan-order reference model and a fairness tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N    = 6;
  localparam int P    = NUM_CDB_PORTS;
  localparam int FAIR = (N + P - 1) / P;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .NUM_PORTS(P)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .NUM_PORTS(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic              t_valid [N];
  logic [PREG_W-1:0] t_preg  [N];
  logic [DATA_W-1:0] t_data  [N];

  int          m_ptr;
  cdb_t        m_cdb  [P];
  int          m_wait [N];
  logic [N-1:0] d_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = t_valid[i];
      bus.req_preg[i]  = t_preg[i];
      bus.req_data[i]  = t_data[i];
    end
  endtask

  // One clock cycle: apply inputs, check registered cdb against the previous
  // prediction, check ready against the scan rule, predict next cdb.
  task automatic step(input logic fl);
    logic [N-1:0] exp_rdy;
    cdb_t         nxt [P];
    int           k, last, idx;
    flush = fl;
    drive();
    #1;
    for (int p = 0; p < P; p++)
      check_eq($sformatf("cdb%0d", p), 64'(bus.cdb[p]), 64'(m_cdb[p]));
    exp_rdy = '0;
    k = 0;
    last = 0;
    for (int p = 0; p < P; p++) nxt[p] = '0;
    if (!fl) begin
      for (int s = 0; s < N; s++) begin
        idx = (m_ptr + s) % N;
        if (t_valid[idx]) begin
          if (t_preg[idx] == 0) begin
            exp_rdy[idx] = 1'b1;
          end else if (k < P) begin
            exp_rdy[idx] = 1'b1;
            nxt[k] = {1'b1, t_preg[idx], t_data[idx]};
            k++;
            last = idx;
          end
        end
      end
      if (k > 0) m_ptr = (last + 1) % N;
    end
    d_ready = bus.req_ready;
    check_eq("ready", 64'(d_ready), 64'(exp_rdy));
    for (int p = 0; p < P; p++) m_cdb[p] = nxt[p];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req(input int i);
    t_valid[i] = ($urandom_range(0, 9) < 7);
    t_preg[i]  = ($urandom_range(0, 7) == 0) ? '0 : PREG_W'($urandom_range(1, 63));
    t_data[i]  = $urandom;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int p = 0; p < P; p++) m_cdb[p] = '0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic all_valid(input int base);
    for (int i = 0; i < N; i++) begin
      t_valid[i] = 1'b1;
      t_preg[i]  = PREG_W'(base + i);
      t_data[i]  = 32'hA000_0000 + 32'(base * 16 + i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic fl;
    rst_n = 1'b0;
    flush = 1'b0;
    all_valid(1);
    drive();
    model_reset();

    // Reset state: outputs cleared and no acceptance while in reset.
    @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_cdb0", 64'(bus.cdb[0]), 64'd0);
    check_eq("rst_cdb1", 64'(bus.cdb[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // p0 bypass alongside two real grants.
    for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
    t_valid[1] = 1'b1; t_preg[1] = 6'd0;  t_data[1] = 32'h1111_1111;
    t_valid[2] = 1'b1; t_preg[2] = 6'd40; t_data[2] = 32'h2222_2222;
    t_valid[3] = 1'b1; t_preg[3] = 6'd41; t_data[3] = 32'h3333_3333;
    step(1'b0);
    check_eq("p0_ready", 64'(d_ready), 64'(6'b001110));
    check_eq("p0_cdb0_preg", 64'(bus.cdb[0].preg), 64'd40);
    check_eq("p0_cdb1_preg", 64'(bus.cdb[1].preg), 64'd41);

    // Single request with payload, visible exactly one cycle.
    for (int i = 0; i < N; i++) t_valid[i] = 1'b0;
    t_valid[0] = 1'b1; t_preg[0] = 6'd33; t_data[0] = 32'hDEAD_BEEF;
    step(1'b0);
    check_eq("single_ready0", 64'(d_ready[0]), 64'd1);
    check_eq("single_cdb0", 64'(bus.cdb[0]), 64'({1'b1, 6'd33, 32'hDEAD_BEEF}));
    t_valid[0] = 1'b0;
    step(1'b0);
    check_eq("single_gone", 64'(bus.cdb[0].valid), 64'd0);

    // Flush: grant from the previous cycle survives, nothing accepted.
    all_valid(10);
    step(1'b0);
    step(1'b1);
    check_eq("flush_ready", 64'(d_ready), 64'd0);
    check_eq("flush_cdb_v", 64'({bus.cdb[1].valid, bus.cdb[0].valid}), 64'd0);
    step(1'b0);
    check_eq("flush_ptr_kept", 64'(d_ready), 64'(6'b011000));

    // Reset asserted while a broadcast is on the bus.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_cdb_v", 64'({bus.cdb[1].valid, bus.cdb[0].valid}), 64'd0);
    check_eq("rstmid_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Oversubscribed, all held: pairs rotate starting from requester 0.
    all_valid(20);
    step(1'b0); check_eq("over_c0", 64'(d_ready), 64'(6'b000011));
    step(1'b0); check_eq("over_c1", 64'(d_ready), 64'(6'b001100));
    step(1'b0); check_eq("over_c2", 64'(d_ready), 64'(6'b110000));
    step(1'b0); check_eq("over_c3", 64'(d_ready), 64'(6'b000011));

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < N; i++) begin
      new_req(i);
      m_wait[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      fl = ($urandom_range(0, 19) == 0);
      step(fl);
      for (int i = 0; i < N; i++) begin
        if (t_valid[i] && !fl && !d_ready[i]) begin
          m_wait[i]++;
          check_eq($sformatf("fair%0d", i), 64'(m_wait[i] < FAIR), 64'd1);
        end else begin
          m_wait[i] = 0;
          new_req(i);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
